// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU (m0) and a loader/DMA (m1).
// Define ARB_M0_PRIORITY_EN to make m0 win every tie instead of using round-robin.
// m1 lock bursts still apply with that macro, including the forced release at LOCK_MAX.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic sel, last_owner, tie_m1, force_m0, grant_m1, access, sel_we;
  logic [CW-1:0] lock_cnt;
`ifdef ARB_M0_PRIORITY_EN
  assign tie_m1 = 1'b0;
`else
  assign tie_m1 = !last_owner;
`endif
  // state register; reset returns to IDLE and drops any pending ack
  always_ff @(posedge clk) state <= !rst ? IDLE : state_nx;
  // next state: requests only matter in IDLE, every transaction is ACCESS then RESP
  always_comb state_nx = state == IDLE ? ((m0_req || m1_req) ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  // arbitration: a saturated lock yields to a waiting m0, an active lock keeps m1, else round-robin
  always_comb begin
    force_m0 = m0_req && lock_cnt == CW'(LOCK_MAX);
    grant_m1 = m1_req && !force_m0 && (lock_cnt != '0 || !m0_req || tie_m1);
  end
  // grant bookkeeping and read-data capture at the closing edge of ACCESS
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel <= 1'b0;
      last_owner <= 1'b1;
      lock_cnt <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (state == IDLE && state_nx == ACCESS) begin
        sel <= grant_m1;
        last_owner <= grant_m1;
        lock_cnt <= grant_m1 && m1_lock ? (lock_cnt == CW'(LOCK_MAX) ? lock_cnt : lock_cnt + CW'(1)) : '0;
      end
      if (access && !sel_we && !sel) m0_rdata <= mem_rdata;
      if (access && !sel_we && sel) m1_rdata <= mem_rdata;
    end
  end
  // memory port, owner and ack outputs; writes and acks are suppressed while reset is held
  always_comb begin
    access = state == ACCESS;
    sel_we = sel ? m1_we : m0_we;
    mem_adr = access ? (sel ? m1_adr : m0_adr) : '0;
    mem_wdata = access ? (sel ? m1_wdata : m0_wdata) : '0;
    mem_we = access && rst && sel_we;
    owner = access ? {sel, !sel} : 2'b00;
    m0_ack = state == RESP && !sel && rst;
    m1_ack = state == RESP && sel && rst;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner sequences and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LOCK_MAX = 8;
`ifdef ARB_M0_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [31:0] m0_adr = '0, m0_wdata = '0, m1_adr = '0, m1_wdata = '0;
  logic m0_ack, m1_ack, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_adr, mem_wdata, mem_rdata;
  logic [1:0] owner;
  logic [31:0] mem [16];
  logic [15:0] mem_ok = '0;
  int n_vec = 0, n_err = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [3:0] i);
    return i == 4'd0 ? 32'hDEADBEEF : 32'hC0DE0000 | 32'(i);
  endfunction

  assign mem_rdata = mem_ok[mem_adr[3:0]] ? mem[mem_adr[3:0]] : f(mem_adr[3:0]);

  always @(posedge clk) if (mem_we) begin
    mem[mem_adr[3:0]] <= mem_wdata;
    mem_ok[mem_adr[3:0]] <= 1'b1;
  end

  typedef struct packed {
    logic [5:0] ci;
    logic [31:0] a0, d0, a1, d1;
    logic [4:0] co;
    logic [31:0] adr, wd, rd0, rd1;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic drive(input logic [5:0] c, input logic [31:0] x0, y0, x1, y1);
    {rst, m0_req, m0_we, m1_req, m1_we, m1_lock} = c;
    m0_adr = x0;
    m0_wdata = y0;
    m1_adr = x1;
    m1_wdata = y1;
  endtask

  function automatic logic [31:0] rnd_adr();
    return ($urandom & 32'hFFFF_FFF0) | 32'h8 | 32'($urandom_range(0, 7));
  endfunction

  int ph, who, t, cyc, free_at, t_at, s;
  bit tv, t_m, t_we, w, last, acc, rsp, seen0, seen1;
  logic [31:0] t_adr, t_wd, t_rd;
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [16];
  logic [1:0] hist [$];

  initial begin
    tbl[0]  = '{6'b011100, 32'h4, 32'h11111111, 32'h8, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{6'b011100, 32'h4, 32'h11111111, 32'h8, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[2]  = '{6'b111100, 32'h4, 32'h11111111, 32'h8, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{6'b111100, 32'h4, 32'h11111111, 32'h8, 32'h0, 5'b01100, 32'h4, 32'h11111111, 32'h0, 32'h0};
    tbl[4]  = '{6'b111100, 32'h4, 32'h11111111, 32'h8, 32'h0, 5'b00010, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[5]  = '{6'b100000, 32'h0, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[6]  = '{6'b110000, 32'h10, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[7]  = '{6'b110000, 32'h10, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h10, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{6'b110000, 32'h10, 32'h0, 32'h0, 32'h0, 5'b00010, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    tbl[9]  = '{6'b100000, 32'h0, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    tbl[10] = '{6'b100110, 32'h0, 32'h0, 32'h1F40, 32'h13, 5'b00000, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    tbl[11] = '{6'b100110, 32'h0, 32'h0, 32'h1F40, 32'h13, 5'b10100, 32'h1F40, 32'h13, 32'hDEADBEEF, 32'h0};
    tbl[12] = '{6'b100110, 32'h0, 32'h0, 32'h1F40, 32'h13, 5'b00001, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    tbl[13] = '{6'b100000, 32'h0, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1 drive(tbl[i].ci, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), 64'({owner, mem_we, m0_ack, m1_ack}), 64'(tbl[i].co));
      chk($sformatf("tbl%0d_adr", i), 64'(mem_adr), 64'(tbl[i].adr));
      chk($sformatf("tbl%0d_wd", i), 64'(mem_wdata), 64'(tbl[i].wd));
      chk($sformatf("tbl%0d_rd0", i), 64'(m0_rdata), 64'(tbl[i].rd0));
      chk($sformatf("tbl%0d_rd1", i), 64'(m1_rdata), 64'(tbl[i].rd1));
    end
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1 drive(6'b110100, 32'h20, 32'h0, 32'h30, 32'h0);
      @(negedge clk);
      ph = k % 3;
      who = PRI ? 0 : (k / 3) % 2;
      chk($sformatf("rr_ack%0d", k), 64'({m0_ack, m1_ack}), 64'({ph == 2 && who == 0, ph == 2 && who == 1}));
      chk($sformatf("rr_own%0d", k), 64'(owner), 64'(ph != 1 ? 2'b00 : who == 0 ? 2'b01 : 2'b10));
    end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1 drive(k == 0 ? 6'b100101 : 6'b110101, 32'h20, 32'h0, 32'h30, 32'h0);
      @(negedge clk);
      ph = k % 3;
      t = k / 3;
      who = t < 8 ? 1 : t == 8 ? 0 : (PRI ? 0 : 1);
      chk($sformatf("lock_ack%0d", k), 64'({m0_ack, m1_ack}), 64'({ph == 2 && who == 0, ph == 2 && who == 1}));
    end
    @(posedge clk); #1 drive(6'b100110, 32'h0, 32'h0, 32'h5, 32'h55);
    @(negedge clk);
    chk("abort_idle", 64'(owner), 64'(2'b00));
    @(posedge clk); #1 drive(6'b000110, 32'h0, 32'h0, 32'h5, 32'h55);
    @(negedge clk);
    chk("abort_we", 64'(mem_we), 64'(1'b0));
    chk("abort_adr", 64'(mem_adr), 64'(32'h5));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 drive(6'b100000, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("abort_ack%0d", k), 64'({m0_ack, m1_ack, owner, mem_we}), 64'(0));
      chk($sformatf("abort_rd%0d", k), {m0_rdata, m1_rdata}, 64'(0));
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = f(4'(i));
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    tv = 1'b0;
    free_at = 0;
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (seen0) m0_req = 1'b0;
      if (seen1) m1_req = 1'b0;
      if (!m0_req && $urandom_range(0, 3) != 0) begin
        m0_req = 1'b1;
        m0_we = 1'($urandom_range(0, 1));
        m0_adr = rnd_adr();
        m0_wdata = $urandom;
      end
      if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1'b1;
        m1_we = 1'($urandom_range(0, 1));
        m1_adr = rnd_adr();
        m1_wdata = $urandom;
        m1_lock = $urandom_range(0, 3) != 0;
      end
      @(negedge clk);
      acc = tv && cyc == t_at + 1;
      rsp = tv && cyc == t_at + 2;
      if (rsp && !t_we) exp_rd[t_m] = t_rd;
      chk("rnd_ctl", 64'({owner, mem_we, m0_ack, m1_ack}), 64'({acc ? (t_m ? 2'b10 : 2'b01) : 2'b00, acc && t_we, rsp && !t_m, rsp && t_m}));
      chk("rnd_bus", {mem_adr, mem_wdata}, acc ? {t_adr, t_wd} : 64'(0));
      chk("rnd_rd", {m0_rdata, m1_rdata}, {exp_rd[0], exp_rd[1]});
      seen0 = m0_ack;
      seen1 = m1_ack;
      if (cyc >= free_at && (m0_req || m1_req)) begin
        s = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i] != 2'b11) break;
          s++;
        end
        last = hist.size() == 0 ? 1'b1 : hist[hist.size() - 1][1];
        if (!m0_req) w = 1'b1;
        else if (!m1_req) w = 1'b0;
        else if (s >= LOCK_MAX) w = 1'b0;
        else if (s > 0) w = 1'b1;
        else w = PRI ? 1'b0 : !last;
        tv = 1'b1;
        t_at = cyc;
        t_m = w;
        t_we = w ? m1_we : m0_we;
        t_adr = w ? m1_adr : m0_adr;
        t_wd = w ? m1_wdata : m0_wdata;
        if (t_we) ref_mem[t_adr[3:0]] = t_wd;
        else t_rd = ref_mem[t_adr[3:0]];
        hist.push_back({w, w && m1_lock});
        if (hist.size() > 32) void'(hist.pop_front());
        free_at = cyc + 3;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two masters.
- Master 0 (m0) is the multi-cycle CPU, covering fetch and lw/sw. Master 1 (m1) is a program loader / debug DMA.
- Three-state FSM with a per-transaction req/ack handshake, round-robin fairness and a bounded m1 lock for burst loading.
- Sits between the CPU datapath address/write-data muxes and the memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LOCK_MAX, 8, max consecutive locked m1 grants while m0 is waiting (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- m0_req  in  1  m0 request, held until m0_ack
- m0_we  in  1  m0 write enable (1 = write, 0 = read)
- m0_adr  in  AW  m0 address
- m0_wdata  in  DW  m0 write data
- m0_ack  out  1  one-cycle completion pulse to m0
- m0_rdata  out  DW  registered read data for m0
- m1_req  in  1  m1 request
- m1_we  in  1  m1 write enable
- m1_adr  in  AW  m1 address
- m1_wdata  in  DW  m1 write data
- m1_lock  in  1  m1 wants to keep ownership after this transaction
- m1_ack  out  1  one-cycle completion pulse to m1
- m1_rdata  out  DW  registered read data for m1
- mem_adr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DW  combinational memory read data
- owner  out  2  00 none, 01 m0, 10 m1 (access-cycle owner)

Behaviour:
- Reset, while rst=0 at a clock edge:
  - state=IDLE, last_owner=m1 (so m0 wins the first tie), lock_cnt=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, owner=00.
  - mem_we=0, mem_adr=0, mem_wdata=0.
- States:
  - IDLE: arbitrate among sampled requests. No request -> stay IDLE. Grant -> ACCESS, latching the granted master into sel.
  - ACCESS (1 cycle): mem_adr/mem_wdata/mem_we driven combinationally from master sel. owner=sel. At the closing edge, mem_rdata is captured into the sel master's rdata register (reads only; rdata holds on writes). Then -> RESP.
  - RESP (1 cycle): sel master's ack=1 and rdata is valid. -> IDLE.
- Outside ACCESS: mem_we=0, mem_adr and mem_wdata hold 0, owner=00.
- Latency: request seen in IDLE cycle T -> memory access in T+1 -> ack and data in T+2. Throughput is one transaction per 3 cycles.
- Handshake:
  - A master holds req/we/adr/wdata stable from req assertion until its ack cycle inclusive.
  - A req still high in the cycle after ack is a new transaction.
  - Request inputs are ignored in ACCESS and RESP. The ack of the non-selected master stays 0.
- Arbitration in IDLE:
  - Only one requester -> grant it.
  - Both requesting -> grant the master that is not last_owner.
  - last_owner is updated on entry to ACCESS.
- m1 lock:
  - On entry to ACCESS for m1 with m1_lock=1, lock_cnt increments, saturating at LOCK_MAX.
  - In IDLE, when m1_req=1 and the previous transaction was a locked m1 grant, m1 wins regardless of round-robin, unless lock_cnt==LOCK_MAX and m0_req=1.
  - In that case m0 is granted and lock_cnt is cleared.
  - lock_cnt also clears whenever m1 is granted with m1_lock=0 or m0 is granted.
- Reset mid-transaction:
  - mem_we is gated with rst, so no memory write occurs in an ACCESS cycle where rst=0.
  - A pending ack is dropped. The aborted transaction is never acknowledged.
- Widths: addresses and data pass through unmodified; there is no byte-lane logic.

Optional Feature:
- Macro ARB_M0_PRIORITY_EN.
- When defined: fixed priority replaces round-robin, so m0 wins every IDLE tie; the m1 lock rules still apply, including forced release at LOCK_MAX.
- When undefined: round-robin as above.

Test Plan:
- Reset: rst=0 for 2 cycles with m0_req=m1_req=1, m0_we=1 -> mem_we=0, acks 0, owner=00, rdata 0. With rst=1, first grant is m0.
- m0 read: m0_adr=0x10, mem_rdata=0xDEADBEEF -> T+1 mem_adr=0x10, mem_we=0, owner=01. T+2 m0_ack=1, m0_rdata=0xDEADBEEF.
- m1 write: m1_adr=0x1F40, m1_wdata=0x00000013 -> T+1 mem_we=1, mem_wdata=0x13, owner=10. T+2 m1_ack=1, m1_rdata unchanged.
- Contention: both request continuously, no lock -> grants alternate m0,m1,m0,m1 across 8 transactions, with acks 3 cycles apart.
- Lock: m1_lock=1 and m0_req=1 throughout, LOCK_MAX=8 -> 8 consecutive m1 acks, then m0 ack, then m1 resumes.
- Reset abort: rst=0 during an m1 write ACCESS cycle -> mem_we=0 that cycle, no m1_ack, IDLE next. Separately, with ARB_M0_PRIORITY_EN and both requesting without lock -> m0 receives every grant.
